// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: word-wide data RAM bus between the load/store unit and the RAM.
//   master (load/store unit): drives bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb;
//                             receives bus_ready, bus_rdata.
//   slave  (RAM)            : the mirror image.
//   bus_valid  transfer request          bus_we     1 = write
//   bus_addr   word address (bits 1:0=0) bus_wdata  lane-replicated store data
//   bus_wstrb  byte enables (0 on loads) bus_ready  transfer accepted/completed this cycle
//   bus_rdata  read word, valid with bus_ready
interface mem_access_unit_if;
   logic        bus_valid;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   modport master (
      output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
      input  bus_ready, bus_rdata
   );

   modport slave (
      input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
      output bus_ready, bus_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store controller between the MEM stage and the data RAM bus.
// Accepts one load/store per instruction, steers byte/half/word lanes, builds write strobes,
// sign/zero-extends loads, stalls the pipeline while a transfer is outstanding and flags
// timed-out (and optionally misaligned) accesses.
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses
// without issuing a bus transfer. Undefined: low address bits below the size are ignored.
//
// Ports:
//   clk, clr (async, active-high)
//   req_valid/req_write/req_size/req_unsigned/req_addr/req_wdata  request from MEM stage
//   stall  freeze upstream pipeline    done   one-cycle completion pulse
//   fault  timeout/misalign with done  rdata  extended load data, held until next completion
//   mem    RAM bus (master side)
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic              done,
   output logic              fault,
   output logic [31:0]       rdata,
   mem_access_unit_if.master mem
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e      state;
   logic [1:0]  size_q;
   logic        unsigned_q;
   logic [1:0]  lane_q;
   logic [7:0]  wait_cnt;

   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic        misalign;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   assign stall = ((state == StIdle) && req_valid) || (state == StAccess);

   // Store steering from the incoming request; registered into the bus outputs on accept.
   always_comb begin
      st_wdata = req_wdata;
      st_wstrb = 4'b1111;
      case (req_size)
         2'b00: begin
            st_wdata = {4{req_wdata[7:0]}};
            st_wstrb = 4'b0001 << req_addr[1:0];
         end
         2'b01: begin
            st_wdata = {2{req_wdata[15:0]}};
            st_wstrb = 4'b0011 << {req_addr[1], 1'b0};
         end
         default: ;
      endcase
      if (!req_write) st_wstrb = 4'b0000;
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_comb begin
      case (req_size)
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = req_addr[0];
         default: misalign = |req_addr[1:0];
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   // Load lane selection and extension from the registered size/lane.
   always_comb begin
      case (lane_q)
         2'd0:    ld_byte = mem.bus_rdata[7:0];
         2'd1:    ld_byte = mem.bus_rdata[15:8];
         2'd2:    ld_byte = mem.bus_rdata[23:16];
         default: ld_byte = mem.bus_rdata[31:24];
      endcase
      ld_half = lane_q[1] ? mem.bus_rdata[31:16] : mem.bus_rdata[15:0];
      case (size_q)
         2'b00:   ld_data = unsigned_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'b01:   ld_data = unsigned_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: ld_data = mem.bus_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state         <= StIdle;
         size_q        <= 2'b00;
         unsigned_q    <= 1'b0;
         lane_q        <= 2'b00;
         wait_cnt      <= 8'd0;
         done          <= 1'b0;
         fault         <= 1'b0;
         rdata         <= 32'd0;
         mem.bus_valid <= 1'b0;
         mem.bus_we    <= 1'b0;
         mem.bus_addr  <= 32'd0;
         mem.bus_wdata <= 32'd0;
         mem.bus_wstrb <= 4'b0000;
      end else begin
         done  <= 1'b0;
         fault <= 1'b0;
         unique case (state)
            StIdle: begin
               if (req_valid) begin
                  size_q        <= req_size;
                  unsigned_q    <= req_unsigned;
                  lane_q        <= req_addr[1:0];
                  wait_cnt      <= 8'd0;
                  mem.bus_we    <= req_write;
                  mem.bus_addr  <= {req_addr[31:2], 2'b00};
                  mem.bus_wdata <= st_wdata;
                  mem.bus_wstrb <= st_wstrb;
                  if (misalign) begin
                     done  <= 1'b1;
                     fault <= 1'b1;
                     rdata <= 32'd0;
                     state <= StResp;
                  end else begin
                     mem.bus_valid <= 1'b1;
                     state         <= StAccess;
                  end
               end
            end
            StAccess: begin
               if (mem.bus_ready) begin
                  if (!mem.bus_we) rdata <= ld_data;
                  mem.bus_valid <= 1'b0;
                  done          <= 1'b1;
                  state         <= StResp;
               end else if (wait_cnt == 8'(TIMEOUT_CYCLES)) begin
                  mem.bus_valid <= 1'b0;
                  done          <= 1'b1;
                  fault         <= 1'b1;
                  rdata         <= 32'd0;
                  state         <= StResp;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            StResp: begin
               wait_cnt <= 8'd0;
               state    <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
